// File: rtl/cdce_spi_pkg.sv
// rtl/cdce_spi_pkg.sv - shared types, mode constants and counter sizing for the CDCE SPI master
package cdce_spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT_LO,
        SHIFT_HI,
        TRAIL,
        DEAD
    } spi_state_t;

    localparam logic CPOL = 1'b0;
    localparam logic CPHA = 1'b0;

    function automatic int ctr_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/cdce_sclk_gen.sv
// rtl/cdce_sclk_gen.sv - half-period tick generator for SCLK, restarted at transaction start
module cdce_sclk_gen
    import cdce_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int              DW     = ctr_w(CLK_DIV);
    localparam logic [DW-1:0]   RELOAD = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt_q, cnt_d;

    // tick marks the last clk cycle of the current half-period
    always_comb begin
        cnt_d = cnt_q;
        if (restart || cnt_q == '0) begin
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/cdce_spi_master.sv
// rtl/cdce_spi_master.sv - SPI mode-0 master for clock-synthesiser configuration words with readback
module cdce_spi_master
    import cdce_spi_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CLK_DIV     = 2,
    parameter int DEAD_CYCLES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] rd_data,
    output logic             sclk,
    output logic             cs_n,
    output logic             mosi,
    input  logic             miso
);

    localparam int             BW        = ctr_w(WIDTH);
    localparam int             DCW       = ctr_w(DEAD_CYCLES);
    localparam logic [BW-1:0]  LAST_BIT  = BW'(WIDTH - 1);
    localparam logic [DCW-1:0] DEAD_LOAD = DCW'(DEAD_CYCLES - 1);

    spi_state_t       state_q, state_d;
    logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DCW-1:0]   dead_cnt_q, dead_cnt_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             sclk_q, sclk_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tick;
    logic             restart;
    logic             accept;

    assign in_ready = (state_q == IDLE) && enable;
    assign accept   = in_ready && in_valid;

    cdce_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk     (clk),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        dead_cnt_d = dead_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        mosi_d     = mosi_q;
        restart    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LEAD;
                    restart = 1'b1;
                    tx_d    = in_data;
                    mosi_d  = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
                end
            end
            LEAD: begin
                if (tick) begin
                    state_d   = SHIFT_LO;
                    bit_cnt_d = '0;
                end
            end
            SHIFT_LO: begin
                if (tick) begin
                    state_d = SHIFT_HI;
                    rx_d    = MSB_FIRST ? {rx_q[WIDTH-2:0], miso} : {miso, rx_q[WIDTH-1:1]};
                end
            end
            SHIFT_HI: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = TRAIL;
                    end else begin
                        state_d   = SHIFT_LO;
                        bit_cnt_d = bit_cnt_q + BW'(1);
                        tx_d      = MSB_FIRST ? (tx_q << 1) : (tx_q >> 1);
                        mosi_d    = MSB_FIRST ? tx_q[WIDTH-2] : tx_q[1];
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    state_d    = DEAD;
                    dead_cnt_d = DEAD_LOAD;
                    mosi_d     = 1'b0;
                end
            end
            DEAD: begin
                if (dead_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    dead_cnt_d = dead_cnt_q - DCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state implies
        sclk_d = (state_d == SHIFT_HI) ? ~CPOL : CPOL;
        cs_n_d = (state_d == IDLE) || (state_d == DEAD);
        busy_d = (state_d != IDLE);
        done_d = (state_d == DEAD) && (dead_cnt_d == '0);
        if (done_d) begin
            rd_data_d = rx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            dead_cnt_q <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            sclk_q     <= CPOL;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            dead_cnt_q <= dead_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rd_data = rd_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_cdce_spi_master.sv
// tb/tb_cdce_spi_master.sv - directed self-checking bench for cdce_spi_master
module tb_cdce_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        enable;

    logic        in_valid_a, in_ready_a, busy_a, done_a, sclk_a, cs_n_a, mosi_a, miso_a, loop_a;
    logic [31:0] in_data_a, rd_data_a;
    logic        in_valid_b, in_ready_b, busy_b, done_b, sclk_b, cs_n_b, mosi_b, miso_b;
    logic [7:0]  in_data_b, rd_data_b;

    assign miso_a = loop_a & mosi_a;
    assign miso_b = mosi_b;

    cdce_spi_master #(.WIDTH(32), .CLK_DIV(2), .DEAD_CYCLES(2), .MSB_FIRST(1'b1)) u_dut_a (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid_a), .in_data(in_data_a),
        .in_ready(in_ready_a), .busy(busy_a), .done(done_a), .rd_data(rd_data_a),
        .sclk(sclk_a), .cs_n(cs_n_a), .mosi(mosi_a), .miso(miso_a)
    );

    cdce_spi_master #(.WIDTH(8), .CLK_DIV(1), .DEAD_CYCLES(2), .MSB_FIRST(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .busy(busy_b), .done(done_b), .rd_data(rd_data_b),
        .sclk(sclk_b), .cs_n(cs_n_b), .mosi(mosi_b), .miso(miso_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int          dcyc, nr, dones, gap, gap_res, bad;
    logic [31:0] mw;
    logic [7:0]  mb;
    logic        first_bit, seen_low, prev;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic xfer_a(input logic [31:0] w, input logic [31:0] hold, input bit drop_en,
                          output int d, output int rises, output logic [31:0] bits);
        logic p;
        d = -1; rises = 0; bits = '0; p = 1'b0;
        @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = w;
        #1;
        check("accept_ready", in_ready_a, 1);
        @(negedge clk);
        in_valid_a = 1'b0;
        in_data_a  = ~w;
        check("cs_n_cycle1", cs_n_a, 0);
        check("busy_cycle1", busy_a, 1);
        for (int c = 1; c <= 300; c++) begin
            if (c > 1) @(negedge clk);
            if (sclk_a && !p) begin
                rises++;
                bits = {bits[30:0], mosi_a};
            end
            p = sclk_a;
            if (c == 60) check("rd_hold", rd_data_a, hold);
            if (drop_en && c == 20) enable = 1'b0;
            if (done_a) begin
                d = c;
                break;
            end
        end
    endtask

    task automatic xfer_b(input logic [7:0] w, output int d, output int rises,
                          output logic [7:0] bits, output logic fb);
        logic p;
        d = -1; rises = 0; bits = '0; p = 1'b0; fb = 1'b0;
        @(negedge clk);
        in_valid_b = 1'b1;
        in_data_b  = w;
        @(negedge clk);
        in_valid_b = 1'b0;
        in_data_b  = ~w;
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) @(negedge clk);
            if (sclk_b && !p) begin
                if (rises == 0) fb = mosi_b;
                if (rises < 8) bits[rises[2:0]] = mosi_b;
                rises++;
            end
            p = sclk_b;
            if (done_b) begin
                d = c;
                break;
            end
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; loop_a = 1'b0;
        in_valid_a = 1'b0; in_data_a = '0; in_valid_b = 1'b0; in_data_b = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_sclk", sclk_a, 0);
        check("rst_cs_n", cs_n_a, 1);
        check("rst_mosi", mosi_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_rd_data", rd_data_a, 0);
        check("rst_in_ready", in_ready_a, 1);
        enable = 1'b0;
        #1;
        check("in_ready_follows_enable", in_ready_a, 0);
        enable = 1'b1;

        // Plan 1: timing and MSB-first bit order
        xfer_a(32'hA5A5_0F0F, 32'h0, 1'b0, dcyc, nr, mw);
        check("t1_done_cycle", dcyc, 134);
        check("t1_sclk_rises", nr, 32);
        check("t1_mosi_word", mw, 32'hA5A5_0F0F);
        @(negedge clk);
        check("t1_busy_after", busy_a, 0);
        check("t1_ready_after", in_ready_a, 1);

        // Plan 2: loopback readback and hold through the next transfer
        loop_a = 1'b1;
        xfer_a(32'h1234_5678, 32'h0, 1'b0, dcyc, nr, mw);
        check("t2_done_cycle", dcyc, 134);
        check("t2_rd_at_done", rd_data_a, 32'h1234_5678);
        xfer_a(32'h8000_0001, 32'h1234_5678, 1'b0, dcyc, nr, mw);
        check("t2b_rd_at_done", rd_data_a, 32'h8000_0001);

        // Plan 3: 8-bit LSB-first, CLK_DIV=1
        xfer_b(8'h01, dcyc, nr, mb, first_bit);
        check("t3_first_bit", first_bit, 1);
        check("t3_bits", mb, 8'h01);
        check("t3_rises", nr, 8);
        check("t3_done_cycle", dcyc, 20);
        check("t3_rd", rd_data_b, 8'h01);
        xfer_b(8'hB4, dcyc, nr, mb, first_bit);
        check("t3b_bits", mb, 8'hB4);
        check("t3b_rd", rd_data_b, 8'hB4);

        // Plan 4: back-to-back with in_valid held high
        dones = 0; gap = 0; gap_res = -1; seen_low = 1'b0;
        @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = 32'hDEAD_BEEF;
        for (int c = 0; c < 400 && dones < 2; c++) begin
            @(negedge clk);
            if (!cs_n_a) begin
                if (seen_low && gap > 0 && gap_res < 0) gap_res = gap;
                seen_low = 1'b1;
            end else if (seen_low) begin
                gap++;
            end
            if (done_a) begin
                dones++;
                if (dones == 1) begin
                    check("t4_rd1", rd_data_a, 32'hDEAD_BEEF);
                    in_data_a = 32'h0BAD_F00D;
                end else begin
                    check("t4_rd2", rd_data_a, 32'h0BAD_F00D);
                    in_valid_a = 1'b0;
                end
            end
        end
        check("t4_dones", dones, 2);
        check("t4_cs_gap", gap_res, 3);

        // Plan 5: reset at the 10th sclk rise
        @(negedge clk);
        in_valid_a = 1'b1;
        in_data_a  = 32'h5A5A_5A5A;
        @(negedge clk);
        in_valid_a = 1'b0;
        nr = 0; prev = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (sclk_a && !prev) nr++;
            prev = sclk_a;
            if (nr == 10) break;
            @(negedge clk);
        end
        check("t5_rises_before_reset", nr, 10);
        reset = 1'b1;
        @(negedge clk);
        check("t5_cs_n", cs_n_a, 1);
        check("t5_sclk", sclk_a, 0);
        check("t5_busy", busy_a, 0);
        check("t5_rd_cleared", rd_data_a, 0);
        check("t5_no_done", done_a, 0);
        reset = 1'b0;
        xfer_a(32'h3C3C_A5A5, 32'h0, 1'b0, dcyc, nr, mw);
        check("t5_after_done_cycle", dcyc, 134);
        check("t5_after_rd", rd_data_a, 32'h3C3C_A5A5);

        // Plan 6: enable low blocks accept; dropping mid-transfer does not abort
        @(negedge clk);
        enable     = 1'b0;
        in_valid_a = 1'b1;
        in_data_a  = 32'hFFFF_FFFF;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (in_ready_a || !cs_n_a || busy_a) bad++;
        end
        check("t6_disabled_bad_cycles", bad, 0);
        in_valid_a = 1'b0;
        enable     = 1'b1;
        xfer_a(32'h0F0F_0F0F, 32'h3C3C_A5A5, 1'b1, dcyc, nr, mw);
        check("t6_drop_done_cycle", dcyc, 134);
        check("t6_drop_rd", rd_data_a, 32'h0F0F_0F0F);
        @(negedge clk);
        check("t6_idle_not_ready", in_ready_a, 0);
        check("t6_idle_busy", busy_a, 0);
        enable = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
